sw_debounce: RTL

- Input conditioning stage directly upstream of the picoMIPS core.
- Takes the raw 9-bit board switch bus and delivers a synchronised, debounced 9-bit bus to the core's SW input:
  - SW[7:0] carries affine-transform operand data.
  - SW[8] is the operator handshake button.
- Also emits single-cycle press/release pulses for SW[8], so the core or a wrapper can count operand loads without seeing contact bounce or metastable values.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_sync2.sv | 29 ++
 rtl/sw_debounce.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the picoMIPS switch conditioning stage.
// Handshake FSM states and the board-rate debounce length.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    UP,
    DOWN_WAIT,
    DOWN,
    UP_WAIT
  } hs_state_t;

  localparam int DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/sw_debounce_sync2.sv
// Two-flop synchroniser for asynchronous board pins.
// Width-parameterised, async active-low reset.
module sync2
  import sw_debounce_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer feeding picoMIPS SW: vector-debounced data plus a
// handshake-button FSM with press/release pulses ('release' is reserved).
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N         = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CW        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [N:0] SW_raw,
  output logic [N:0] SW,
  output logic       press,
  output logic       release_p,
  output logic       busy
);

  logic [N:0]    w_s2;
  logic [CW-1:0] w_last;

  logic [N-1:0]  r_cand;
  logic [N-1:0]  r_data;
  logic [CW-1:0] r_dcnt;

  hs_state_t     r_state;
  logic [CW-1:0] r_hcnt;
  logic          r_btn;
  logic          r_press;
  logic          r_rel;
  logic          r_busy;

  assign w_last = CW'(DB_CYCLES - 1);

  sync2 #(
    .W(N + 1)
  ) u_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (SW_raw),
    .o_q    (w_s2)
  );

  // One counter for the whole data vector: any bit moving restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cand <= '0;
      r_data <= '0;
      r_dcnt <= '0;
    end else if (w_s2[N-1:0] != r_cand) begin
      r_cand <= w_s2[N-1:0];
      r_dcnt <= '0;
    end else if (r_cand != r_data) begin
      if (r_dcnt == w_last)
        r_data <= r_cand;
      else
        r_dcnt <= r_dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= UP;
      r_hcnt  <= '0;
      r_btn   <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      case (r_state)
        UP: begin
          if (w_s2[N]) begin
            r_state <= DOWN_WAIT;
            r_hcnt  <= '0;
          end
        end
        DOWN_WAIT: begin
          if (!w_s2[N]) begin
            r_state <= UP;
          end else if (r_hcnt == w_last) begin
            r_state <= DOWN;
            r_btn   <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        DOWN: begin
          if (!w_s2[N]) begin
            r_state <= UP_WAIT;
            r_hcnt  <= '0;
          end
        end
        UP_WAIT: begin
          if (w_s2[N]) begin
            r_state <= DOWN;
          end else if (r_hcnt == w_last) begin
            r_state <= UP;
            r_btn   <= 1'b0;
            r_rel   <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        default: r_state <= UP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_busy <= 1'b0;
    else
      r_busy <= (r_cand != r_data) ||
                (r_state == DOWN_WAIT) ||
                (r_state == UP_WAIT);
  end

  assign SW        = {r_btn, r_data};
  assign press     = r_press;
  assign release_p = r_rel;
  assign busy      = r_busy;

endmodule
